// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC and fetch-tracking state for the instruction-fetch stage.
// ITCM geometry mirrors the legacy ITCM_RAM_* macros so existing instantiations keep their port widths.
package ifu_fetch_pkg;

   localparam int unsigned ITCM_RAM_AW = 16;
   localparam int unsigned ITCM_RAM_DW = 32;
   localparam int unsigned ITCM_RAM_MW = ITCM_RAM_DW / 8;
   localparam int unsigned INSTR_W     = 32;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Tracks the single outstanding ITCM read; KILL means its data must be discarded.
   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_KILL = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Two-entry synchronous FIFO holding {pc, instr} pairs between the ITCM and decode.
// Flush wins over push/pop in the same cycle.
module ifu_fetch_fifo #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         do_push;
   logic         do_pop;

   always_comb begin
      do_pop  = pop & (count != 2'd0);
      do_push = push & ((count != 2'd2) | do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads to the ITCM, and buffers
// returned instructions with their PC for decode. Handles redirects and fetch halt.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fetch_halt,
   input  logic                   redirect_valid,
   input  logic [PC_W-1:0]        redirect_pc,
   output logic                   ifu2itcm_cmd_valid,
   input  logic                   ifu2itcm_cmd_ready,
   output logic                   ifu2itcm_cmd_read,
   output logic [ITCM_RAM_AW-1:0] ifu2itcm_cmd_addr,
   output logic [ITCM_RAM_MW-1:0] ifu2itcm_cmd_wmask,
   output logic [ITCM_RAM_DW-1:0] ifu2itcm_cmd_wdata,
   input  logic                   ifu2itcm_rsp_valid,
   output logic                   ifu2itcm_rsp_ready,
   input  logic [ITCM_RAM_DW-1:0] ifu2itcm_rsp_rdata,
   output logic                   if2id_valid,
   input  logic                   if2id_ready,
   output logic [ITCM_RAM_DW-1:0] if2id_instr,
   output logic [PC_W-1:0]        if2id_pc
);

   localparam int unsigned     ENTRY_W  = PC_W + ITCM_RAM_DW;
   localparam logic [PC_W-1:0] ALIGN_MK = ~PC_W'(3);

   fetch_state_e       state;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    inflight_pc;
   logic [PC_W-1:0]    redirect_tgt;
   logic [1:0]         count;
   logic               cmd_fire;
   logic               rsp_zero;
   logic               push;
   logic               pop;
   logic [PC_W-1:0]    push_pc;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head;

   // Issue never looks at rsp_valid: the ITCM may answer combinationally in the same cycle.
   assign ifu2itcm_cmd_valid = ~rst & ~fetch_halt & ~redirect_valid
                             & (state == FETCH_IDLE) & (count != 2'd2);
   assign ifu2itcm_cmd_read  = 1'b1;
   assign ifu2itcm_cmd_addr  = pc[ITCM_RAM_AW+1:2];
   assign ifu2itcm_cmd_wmask = '0;
   assign ifu2itcm_cmd_wdata = '0;
   assign ifu2itcm_rsp_ready = 1'b1;

   always_comb begin
      redirect_tgt = redirect_pc & ALIGN_MK;
      cmd_fire     = ifu2itcm_cmd_valid & ifu2itcm_cmd_ready;
      rsp_zero     = cmd_fire & ifu2itcm_rsp_valid;
      push         = ~redirect_valid & ifu2itcm_rsp_valid
                   & (rsp_zero | (state == FETCH_WAIT));
      push_pc      = rsp_zero ? pc : inflight_pc;
      push_entry   = {push_pc, ifu2itcm_rsp_rdata};
      pop          = if2id_valid & if2id_ready & ~redirect_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC & ALIGN_MK;
         inflight_pc <= '0;
         state       <= FETCH_IDLE;
      end else begin
         if (redirect_valid) begin
            pc <= redirect_tgt;
         end else if (cmd_fire) begin
            pc <= pc + PC_W'(4);
         end
         case (state)
            FETCH_IDLE: begin
               if (cmd_fire & ~ifu2itcm_rsp_valid) begin
                  state       <= FETCH_WAIT;
                  inflight_pc <= pc;
               end
            end
            FETCH_WAIT: begin
               if (ifu2itcm_rsp_valid) begin
                  state <= FETCH_IDLE;
               end else if (redirect_valid) begin
                  state <= FETCH_KILL;
               end
            end
            FETCH_KILL: begin
               if (ifu2itcm_rsp_valid) begin
                  state <= FETCH_IDLE;
               end
            end
            default: state <= FETCH_IDLE;
         endcase
      end
   end

   ifu_fetch_fifo #(.W(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (push_entry),
      .dout  (head),
      .count (count)
   );

   assign if2id_valid = (count != 2'd0);
   assign if2id_pc    = head[ENTRY_W-1 -: PC_W];
   assign if2id_instr = head[ITCM_RAM_DW-1:0];

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the fetch stream and an ITCM responder.
module tb_ifu_fetch;
   import ifu_fetch_pkg::*;

   localparam int unsigned AW = ITCM_RAM_AW;
   localparam int unsigned DW = ITCM_RAM_DW;
   localparam int unsigned MW = ITCM_RAM_MW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fetch_halt = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = '0;
   logic          cmd_valid, cmd_read, rsp_ready;
   logic          cmd_ready = 1'b0;
   logic [AW-1:0] cmd_addr;
   logic [MW-1:0] cmd_wmask;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          id_valid;
   logic          id_ready = 1'b0;
   logic [DW-1:0] id_instr;
   logic [31:0]   id_pc;

   logic          w_cmd_valid, w_cmd_read, w_rsp_ready, w_id_valid;
   logic [AW-1:0] w_cmd_addr;
   logic [MW-1:0] w_cmd_wmask;
   logic [DW-1:0] w_cmd_wdata, w_id_instr;
   logic [31:0]   w_id_pc;

   // ITCM responder state and reference-model state
   int unsigned   lat = 0;
   logic          pend_active = 1'b0;
   int unsigned   pend_cnt = 0;
   logic [AW-1:0] pend_addr = '0;
   logic          spur = 1'b0;
   logic          const_mem = 1'b0;
   logic          sv_fire, sv_rsp;
   logic [AW-1:0] sv_addr;
   logic [31:0]   exp_cmd_pc = '0;
   logic [31:0]   exp_del_pc = '0;
   logic [31:0]   next_pc;
   int            ndeliv = 0;
   int            d0, k, hdel;
   logic          found;
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input logic cm);
      return cm ? 32'h0000_0013 : ((32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0013);
   endfunction

   assign rsp_valid = spur | ((lat == 0) ? (cmd_valid & cmd_ready)
                                         : (pend_active && pend_cnt == 0));
   assign rsp_rdata = (lat == 0) ? mem_word(cmd_addr, const_mem) : mem_word(pend_addr, const_mem);

   ifu_fetch dut (
      .clk(clk), .rst(rst), .fetch_halt(fetch_halt),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ifu2itcm_cmd_valid(cmd_valid), .ifu2itcm_cmd_ready(cmd_ready),
      .ifu2itcm_cmd_read(cmd_read), .ifu2itcm_cmd_addr(cmd_addr),
      .ifu2itcm_cmd_wmask(cmd_wmask), .ifu2itcm_cmd_wdata(cmd_wdata),
      .ifu2itcm_rsp_valid(rsp_valid), .ifu2itcm_rsp_ready(rsp_ready),
      .ifu2itcm_rsp_rdata(rsp_rdata),
      .if2id_valid(id_valid), .if2id_ready(id_ready),
      .if2id_instr(id_instr), .if2id_pc(id_pc)
   );

   ifu_fetch #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst), .fetch_halt(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .ifu2itcm_cmd_valid(w_cmd_valid), .ifu2itcm_cmd_ready(1'b1),
      .ifu2itcm_cmd_read(w_cmd_read), .ifu2itcm_cmd_addr(w_cmd_addr),
      .ifu2itcm_cmd_wmask(w_cmd_wmask), .ifu2itcm_cmd_wdata(w_cmd_wdata),
      .ifu2itcm_rsp_valid(w_cmd_valid), .ifu2itcm_rsp_ready(w_rsp_ready),
      .ifu2itcm_rsp_rdata(32'h0000_0013),
      .if2id_valid(w_id_valid), .if2id_ready(1'b1),
      .if2id_instr(w_id_instr), .if2id_pc(w_id_pc)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Settle this cycle's inputs and check the fetch stream against the model.
   task automatic settle();
      #1;
      sv_fire = cmd_valid & cmd_ready;
      sv_rsp  = rsp_valid & ~spur & (lat != 0);
      sv_addr = cmd_addr;
      if (redirect_valid) begin
         chk("no_cmd_on_redirect", 64'(cmd_valid), 64'(1'b0));
         exp_cmd_pc = redirect_pc & ~32'h3;
         exp_del_pc = redirect_pc & ~32'h3;
      end else begin
         if (fetch_halt) chk("no_cmd_on_halt", 64'(cmd_valid), 64'(1'b0));
         if (cmd_valid && cmd_ready) begin
            chk("cmd_addr", 64'(cmd_addr), 64'(exp_cmd_pc[AW+1:2]));
            exp_cmd_pc = exp_cmd_pc + 32'd4;
         end
         if (id_valid && id_ready) begin
            chk("id_pc", 64'(id_pc), 64'(exp_del_pc));
            chk("id_instr", 64'(id_instr), 64'(mem_word(exp_del_pc[AW+1:2], const_mem)));
            exp_del_pc = exp_del_pc + 32'd4;
            ndeliv++;
         end
      end
   endtask

   // Clock edge, then advance the ITCM responder by one cycle.
   task automatic advance();
      @(posedge clk);
      @(negedge clk);
      if (sv_rsp) pend_active = 1'b0;
      else if (pend_active && pend_cnt != 0) pend_cnt--;
      if (sv_fire && lat != 0) begin
         pend_active = 1'b1;
         pend_cnt    = lat - 1;
         pend_addr   = sv_addr;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         advance();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; fetch_halt = 1'b0; spur = 1'b0;
      pend_active = 1'b0;
      #1;
      chk("rst_cmd_valid", 64'(cmd_valid), 64'(1'b0));
      chk("rst_id_valid", 64'(id_valid), 64'(1'b0));
      chk("rst_id_pc", 64'(id_pc), 64'(32'h0));
      chk("rst_id_instr", 64'(id_instr), 64'(32'h0));
      chk("rst_wrap_cmd_valid", 64'(w_cmd_valid), 64'(1'b0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_cmd_pc = '0;
      exp_del_pc = '0;
   endtask

   task automatic wait_fire(input string tag);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         settle();
         found = sv_fire;
         advance();
      end
      chk(tag, 64'(found), 64'(1'b1));
   endtask

   initial begin
      @(negedge clk);
      // Zero-latency ITCM, decode always ready; wrap instance runs alongside
      lat = 0; cmd_ready = 1'b1; id_ready = 1'b1; const_mem = 1'b1;
      do_reset();
      chk("const_read", 64'(cmd_read), 64'(1'b1));
      chk("const_wmask", 64'(cmd_wmask), 64'(0));
      chk("const_wdata", 64'(cmd_wdata), 64'(0));
      chk("const_rsp_ready", 64'(rsp_ready), 64'(1'b1));
      for (int i = 0; i < 6; i++) begin
         settle();
         chk("t1_cmd_valid", 64'(cmd_valid), 64'(1'b1));
         chk("t1_cmd_addr", 64'(cmd_addr), 64'(i));
         chk("t1_id_valid", 64'(id_valid), 64'(i > 0));
         if (i > 0) chk("t1_id_pc", 64'(id_pc), 64'(4 * (i - 1)));
         if (i == 0) chk("t6_first_addr", 64'(w_cmd_addr), 64'(16'hFFFF));
         if (i == 1) chk("t6_wrap_addr", 64'(w_cmd_addr), 64'(0));
         if (i == 1) chk("t6_first_pc", 64'(w_id_pc), 64'(32'hFFFF_FFFC));
         if (i == 2) chk("t6_wrap_pc", 64'(w_id_pc), 64'(32'h0));
         advance();
      end

      // 1-cycle ITCM with decode stalled: two entries buffer, then issue stops
      const_mem = 1'b0; lat = 1; id_ready = 1'b0;
      do_reset();
      run(8);
      settle();
      chk("t2_full_no_cmd", 64'(cmd_valid), 64'(1'b0));
      chk("t2_head_valid", 64'(id_valid), 64'(1'b1));
      chk("t2_head_pc", 64'(id_pc), 64'(32'h0));
      advance();
      id_ready = 1'b1;
      settle();
      chk("t2_pop0_pc", 64'(id_pc), 64'(32'h0));
      chk("t2_pop0_no_cmd", 64'(cmd_valid), 64'(1'b0));
      advance();
      settle();
      chk("t2_pop1_pc", 64'(id_pc), 64'(32'h4));
      chk("t2_resume_valid", 64'(cmd_valid), 64'(1'b1));
      chk("t2_resume_addr", 64'(cmd_addr), 64'(2));
      advance();

      // Redirect in the cycle the in-flight response for 0x10 returns
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         settle();
         found = sv_fire && (cmd_addr == AW'(4));
         advance();
      end
      chk("t3_fire_0x10", 64'(found), 64'(1'b1));
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      settle();
      chk("t3_rsp_same_cycle", 64'(rsp_valid), 64'(1'b1));
      advance();
      redirect_valid = 1'b0;
      settle();
      chk("t3_target_cmd", 64'(cmd_valid), 64'(1'b1));
      chk("t3_target_addr", 64'(cmd_addr), 64'(16'h0040));
      advance();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         settle();
         if (id_valid) begin
            found = 1'b1;
            chk("t3_first_pc", 64'(id_pc), 64'(32'h0000_0100));
         end
         advance();
      end
      chk("t3_delivered", 64'(found), 64'(1'b1));

      // Redirect while a 3-cycle read is outstanding: its data must be killed
      fetch_halt = 1'b1; run(3); fetch_halt = 1'b0;
      lat = 3;
      wait_fire("t3b_fire");
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1236;
      settle(); advance();
      redirect_valid = 1'b0;
      found = 1'b0; k = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         settle();
         if (cmd_valid) begin
            found = 1'b1;
            k = i;
            chk("t3b_target_addr", 64'(cmd_addr), 64'(16'h048D));
         end
         advance();
      end
      chk("t3b_wait_cycles", 64'(k), 64'(2));
      run(10);

      // Redirect with a full queue and decode ready: queue empties, no stale pop
      fetch_halt = 1'b1; run(6); fetch_halt = 1'b0;
      lat = 0; id_ready = 1'b0;
      run(4);
      settle();
      chk("t4_full_valid", 64'(id_valid), 64'(1'b1));
      chk("t4_full_no_cmd", 64'(cmd_valid), 64'(1'b0));
      advance();
      id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      d0 = ndeliv;
      settle(); advance();
      redirect_valid = 1'b0;
      settle();
      chk("t4_flushed", 64'(id_valid), 64'(1'b0));
      chk("t4_target_addr", 64'(cmd_addr), 64'(16'h0080));
      chk("t4_no_stale_pop", 64'(ndeliv), 64'(d0));
      advance();
      run(3);

      // Spurious response with nothing outstanding is ignored; then halt with one in flight
      fetch_halt = 1'b1; run(4);
      spur = 1'b1; settle(); advance(); spur = 1'b0;
      settle();
      chk("spur_ignored", 64'(id_valid), 64'(1'b0));
      advance();
      lat = 2; fetch_halt = 1'b0;
      settle();
      chk("t5_fire", 64'(sv_fire), 64'(1'b1));
      next_pc = exp_cmd_pc;
      advance();
      fetch_halt = 1'b1; hdel = ndeliv;
      run(5);
      chk("t5_one_delivered", 64'(ndeliv - hdel), 64'(1));
      fetch_halt = 1'b0;
      settle();
      chk("t5_resume_valid", 64'(cmd_valid), 64'(1'b1));
      chk("t5_resume_addr", 64'(cmd_addr), 64'(next_pc[AW+1:2]));
      advance();

      // Randomized traffic against the stream model
      do_reset();
      d0 = ndeliv;
      for (int i = 0; i < 1500; i++) begin
         if (!pend_active && ($urandom_range(0, 19) == 0)) lat = $urandom_range(0, 3);
         fetch_halt     = ($urandom_range(0, 9) == 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = $urandom;
         id_ready       = ($urandom_range(0, 9) < 7);
         cmd_ready      = ($urandom_range(0, 9) < 8);
         settle();
         advance();
      end
      chk("rand_progress", 64'(ndeliv - d0 > 100), 64'(1'b1));
      fetch_halt = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1; cmd_ready = 1'b1;
      d0 = ndeliv;
      run(20);
      chk("drain_progress", 64'(ndeliv - d0 >= 5), 64'(1'b1));

      // Mid-operation asynchronous reset
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage that sits directly upstream of the ITCM controller. It owns the program counter and issues word-aligned read commands to the ITCM over the `ifu2itcm_cmd_*` / `ifu2itcm_rsp_*` handshake. Returned instructions are buffered with their PC in a 2-entry queue and presented to decode over a valid/ready interface. It also handles branch/jump redirects and an external fetch halt.

## Interface
- `PC_W`, 32: program counter width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `fetch_halt`  in  1: when 1, no new command is issued; an in-flight request still completes.
- `redirect_valid`  in  1: single-cycle redirect request.
- `redirect_pc`  in  PC_W: redirect target; bits [1:0] are ignored and forced to 0.
- `ifu2itcm_cmd_valid`  out  1: read command valid.
- `ifu2itcm_cmd_ready`  in  1: ITCM accepts command.
- `ifu2itcm_cmd_read`  out  1: constant 1.
- `ifu2itcm_cmd_addr`  out  `ITCM_RAM_AW`: word address, equal to pc[`ITCM_RAM_AW+1:2].
- `ifu2itcm_cmd_wmask`  out  `ITCM_RAM_MW`: constant 0.
- `ifu2itcm_cmd_wdata`  out  `ITCM_RAM_DW`: constant 0.
- `ifu2itcm_rsp_valid`  in  1: read data valid.
- `ifu2itcm_rsp_ready`  out  1: constant 1. Queue space is reserved before a command is issued.
- `ifu2itcm_rsp_rdata`  in  `ITCM_RAM_DW`: instruction word.
- `if2id_valid`  out  1: instruction available to decode.
- `if2id_ready`  in  1: decode accepts.
- `if2id_instr`  out  `ITCM_RAM_DW`: instruction.
- `if2id_pc`  out  PC_W: PC of the instruction.

## Operation
Registers:
- `pc`: next fetch address.
- `inflight`: 0 or 1.
- `inflight_pc`.
- `kill`: drop the next response.
- 2-entry queue of {pc, instr} with a `count` of 0 to 2.

Command issue:
- `ifu2itcm_cmd_valid` = !rst_state & !fetch_halt & !redirect_valid & (inflight==0) & (count < 2).
- It depends only on registered state plus the halt and redirect inputs. It never depends on `rsp_valid`, because the ITCM may return a response combinationally in the same cycle as the command.
- On a command handshake: `pc` <= pc+4 (wraps modulo 2^PC_W, so 0xFFFF_FFFC -> 0). Upper PC bits above the ITCM address field alias.

Response association:
- Zero-latency response (`rsp_valid` in the same cycle as the command handshake): the request never becomes in flight. {pc, rdata} is pushed.
- Otherwise the command handshake sets `inflight`=1 and `inflight_pc`=pc. A later response pushes {inflight_pc, rdata} and clears `inflight`.
- A `rsp_valid` with no matching request is a protocol error and is ignored.

Queue:
- Push on response, pop on `if2id_valid & if2id_ready`; both may happen in the same cycle.
- The head drives `if2id_*`.
- Order is preserved.
- Overflow is impossible by construction: issue requires count+inflight < 2.

Redirect (highest priority):
- Queue is cleared, including any pop in the same cycle.
- `pc` <= {redirect_pc[PC_W-1:2], 2'b00}.
- No command is issued that cycle.
- A response arriving in the same cycle is dropped.
- If `inflight`=1 and no response arrives that cycle, `kill` is set. The next response is dropped and clears `kill` and `inflight`.
- Fetch resumes at the target once `inflight`=0.

Halt:
- Blocks issue only.
- The queue keeps draining and in-flight responses are still pushed.

## Timing
- Reset values: `ifu2itcm_cmd_valid`=0, `if2id_valid`=0, `if2id_instr`=0, `if2id_pc`=0, `pc`=RESET_PC, `inflight`=0, `kill`=0, `count`=0.
- First command is issued in the first cycle after `rst` deasserts.
- Latency from command handshake to `if2id_valid` is 1 cycle plus the ITCM latency (with a zero-latency ITCM: 1 cycle).
- Throughput:
  - Zero-latency ITCM: 1 instruction/cycle.
  - 1-cycle ITCM: 1 instruction per 2 cycles.
- A redirect asserted in cycle N with nothing in flight produces a command at the target in cycle N+1.
- `rst` asserted mid-operation clears all state immediately. A pending response is then ignored.

## Structure
- `RESET_PC` default, the 32-bit instruction width and the existing `ITCM_RAM_AW`/`ITCM_RAM_DW`/`ITCM_RAM_MW` macros live in `defines.v`.
- One sub-module, `ifu_fetch_fifo`: a 2-entry synchronous FIFO of width PC_W+`ITCM_RAM_DW`, with a flush input, `clk`/`rst`, and count output.

## Test plan
1. Reset, zero-latency ITCM returning 0x0000_0013, decode always ready -> commands at addr 0,1,2,… every cycle; `if2id_pc` 0x0,0x4,0x8 on consecutive cycles starting cycle 2.
2. 1-cycle ITCM, `if2id_ready`=0 -> exactly 2 instructions buffered, then `cmd_valid` stays 0. Raising ready drains PC 0x0 then 0x4 in order, and fetch resumes at 0x8.
3. In-flight request for 0x10 with a 1-cycle ITCM, redirect to 0x103 in the same cycle -> the response for 0x10 is dropped; the next command has addr 0x40 (PC 0x100); first `if2id_pc`=0x100.
4. Redirect asserted while the queue is full and `if2id_ready`=1 -> the queue is emptied; `if2id_valid`=0 the next cycle; no pop of a stale entry is counted.
5. `fetch_halt`=1 for 5 cycles with one request in flight -> the in-flight instruction is delivered and no new command is issued; issue resumes at the next PC when halt drops.
6. `RESET_PC`=0xFFFF_FFFC -> second fetch PC is 0x0000_0000 (wrap).
